// File: rtl/bridge_arb_pkg.sv
// ============================================================================
// Module  : bridge_arb_pkg
// Brief   : Shared types and constants for the AHB bridge arbiter.
//           BRIDGE_ARB_LOCK_EN adds the LOCKED arbitration state.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bridge_arb_pkg;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

  localparam int c_NUM_MASTERS_DEF    = 3;
  localparam int c_MAX_BEATS_DEF      = 8;
  localparam int c_DEFAULT_MASTER_DEF = 0;

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_OWN    = 2'd1
`ifdef BRIDGE_ARB_LOCK_EN
    ,
    ST_LOCKED = 2'd2
`endif
  } arb_state_t;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY do not.
  function automatic logic is_beat(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_bridge_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker; searches from last+1 upward.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_MASTERS = 3
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [1:0]             last,
  output logic [NUM_MASTERS-1:0] win,
  output logic [1:0]             win_idx
);

  logic [1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    win     = '0;
    win_idx = last;
    w_idx   = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      w_idx = 2'((int'(last) + i) % NUM_MASTERS);
      if (req[w_idx]) begin
        win        = '0;
        win[w_idx] = 1'b1;
        win_idx    = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ahb_bridge_arbiter.sv
// ============================================================================
// Module  : ahb_bridge_arbiter
// Brief   : Round-robin AHB arbiter for masters sharing one bridge port.
//           Define BRIDGE_ARB_LOCK_EN to honour Hlock (LOCKED tenures).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_bridge_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = c_NUM_MASTERS_DEF,
  parameter int MAX_BEATS      = c_MAX_BEATS_DEF,
  parameter int DEFAULT_MASTER = c_DEFAULT_MASTER_DEF
) (
  input  logic                   Hclk,
  input  logic                   Hresetn,
  input  logic [NUM_MASTERS-1:0] Hbusreq,
  input  logic [NUM_MASTERS-1:0] Hlock,
  input  logic [1:0]             Htrans,
  input  logic                   Hreadyout,
  output logic [NUM_MASTERS-1:0] Hgrant,
  output logic [1:0]             Hmaster,
  output logic [1:0]             Hmaster_data,
  output logic                   Hmastlock
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0]          c_MAX       = CW'(MAX_BEATS);
  localparam logic [NUM_MASTERS-1:0] c_DEF_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [1:0]             c_DEF_IDX   = 2'(DEFAULT_MASTER);

  arb_state_t             r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [1:0]             r_ptr, w_ptr_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [1:0]             r_hmaster, r_hmaster_data;
  logic [1:0]             w_owner;
  logic [NUM_MASTERS-1:0] w_others, w_win;
  logic [1:0]             w_win_idx;
  logic                   w_rearb, w_beat;

  always_comb begin
    w_owner = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[i]) w_owner = 2'(i);
    end
  end

  assign w_others = Hbusreq & ~r_grant;
  assign w_beat   = is_beat(Htrans);

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_pick (
    .req     (Hbusreq),
    .last    (r_ptr),
    .win     (w_win),
    .win_idx (w_win_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_rearb     = 1'b0;
    case (r_state)
      ST_PARK: w_rearb = |Hbusreq;
      ST_OWN: begin
        if (!Hbusreq[w_owner]) begin
          w_rearb = 1'b1;
        end else if ((|w_others) &&
                     ((r_cnt == c_MAX) || (Htrans == c_HTRANS_IDLE))) begin
          w_rearb = 1'b1;
        end else if (r_cnt == c_MAX) begin
          // Sole requester keeps the bus and starts a fresh tenure.
          w_cnt_nxt = '0;
        end else if (w_beat) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
`ifdef BRIDGE_ARB_LOCK_EN
      ST_LOCKED: w_rearb = !Hlock[w_owner];
`endif
      default: w_state_nxt = ST_PARK;
    endcase

    if (w_rearb) begin
      w_cnt_nxt = '0;
      if (|Hbusreq) begin
        w_grant_nxt = w_win;
        w_ptr_nxt   = w_win_idx;
`ifdef BRIDGE_ARB_LOCK_EN
        w_state_nxt = (|(w_win & Hlock)) ? ST_LOCKED : ST_OWN;
`else
        w_state_nxt = ST_OWN;
`endif
      end else begin
        w_grant_nxt = c_DEF_GRANT;
        w_state_nxt = ST_PARK;
      end
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state        <= ST_PARK;
      r_grant        <= c_DEF_GRANT;
      r_ptr          <= c_DEF_IDX;
      r_cnt          <= '0;
      r_hmaster      <= c_DEF_IDX;
      r_hmaster_data <= c_DEF_IDX;
    end else if (Hreadyout) begin
      r_state        <= w_state_nxt;
      r_grant        <= w_grant_nxt;
      r_ptr          <= w_ptr_nxt;
      r_cnt          <= w_cnt_nxt;
      r_hmaster      <= w_owner;
      r_hmaster_data <= r_hmaster;
    end
  end

`ifdef BRIDGE_ARB_LOCK_EN
  logic r_mastlock;

  // Lock status follows the grant into the address phase, like Hmaster.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_mastlock <= 1'b0;
    end else if (Hreadyout) begin
      r_mastlock <= (r_state == ST_LOCKED);
    end
  end

  assign Hmastlock = r_mastlock;
`else
  logic w_unused_lock;
  assign w_unused_lock = ^Hlock;
  assign Hmastlock     = 1'b0;
`endif

  assign Hgrant       = r_grant;
  assign Hmaster      = r_hmaster;
  assign Hmaster_data = r_hmaster_data;

endmodule

`default_nettype wire

// File: tb/tb_ahb_bridge_arbiter.sv
// ============================================================================
// Module  : tb_ahb_bridge_arbiter
// Brief   : Directed bench for ahb_bridge_arbiter (3 masters, 8 beats).
//           Lock scenario is built only with BRIDGE_ARB_LOCK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_bridge_arbiter;

  logic       Hclk;
  logic       Hresetn;
  logic [2:0] Hbusreq;
  logic [2:0] Hlock;
  logic [1:0] Htrans;
  logic       Hreadyout;
  logic [2:0] Hgrant;
  logic [1:0] Hmaster;
  logic [1:0] Hmaster_data;
  logic       Hmastlock;

  int n_checks = 0;
  int n_errors = 0;

  ahb_bridge_arbiter #(
    .NUM_MASTERS    (3),
    .MAX_BEATS      (8),
    .DEFAULT_MASTER (0)
  ) dut (
    .Hclk         (Hclk),
    .Hresetn      (Hresetn),
    .Hbusreq      (Hbusreq),
    .Hlock        (Hlock),
    .Htrans       (Htrans),
    .Hreadyout    (Hreadyout),
    .Hgrant       (Hgrant),
    .Hmaster      (Hmaster),
    .Hmaster_data (Hmaster_data),
    .Hmastlock    (Hmastlock)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge Hclk);
    #1;
  endtask

  initial begin
    Hresetn   = 1'b0;
    Hbusreq   = 3'b000;
    Hlock     = 3'b000;
    Htrans    = 2'b00;
    Hreadyout = 1'b1;
    tick(3);
    check("rst_grant", Hgrant, 3'b001);
    check("rst_hmaster", Hmaster, 2'd0);
    check("rst_hmaster_data", Hmaster_data, 2'd0);
    check("rst_mastlock", Hmastlock, 1'b0);

    // Idle after release: parked on the default master.
    Hresetn = 1'b1;
    tick(5);
    check("park_grant", Hgrant, 3'b001);
    check("park_hmaster", Hmaster, 2'd0);
    check("park_mastlock", Hmastlock, 1'b0);

    // M1 and M2 streaming: each tenure is 8 counted beats plus the handover edge.
    Hbusreq = 3'b110;
    Htrans  = 2'b10;
    tick(1);
    check("rr_e1_grant", Hgrant, 3'b010);
    check("rr_e1_hmaster", Hmaster, 2'd0);
    tick(1);
    check("rr_e2_hmaster", Hmaster, 2'd1);
    check("rr_e2_hmaster_data", Hmaster_data, 2'd0);
    tick(7);
    check("rr_e9_grant", Hgrant, 3'b010);
    tick(1);
    check("rr_e10_grant", Hgrant, 3'b100);
    check("rr_e10_hmaster", Hmaster, 2'd1);
    check("rr_e10_hmaster_data", Hmaster_data, 2'd1);
    tick(1);
    check("rr_e11_hmaster", Hmaster, 2'd2);
    check("rr_e11_hmaster_data", Hmaster_data, 2'd1);
    tick(1);
    check("rr_e12_hmaster_data", Hmaster_data, 2'd2);
    tick(6);
    check("rr_e18_grant", Hgrant, 3'b100);
    tick(1);
    check("rr_e19_grant", Hgrant, 3'b010);

    // Three beats into M1's tenure, stall for 5 cycles; counter must freeze at 3.
    tick(3);
    check("pre_stall_hmaster", Hmaster, 2'd1);
    Hreadyout = 1'b0;
    tick(5);
    check("stall_grant", Hgrant, 3'b010);
    check("stall_hmaster", Hmaster, 2'd1);
    check("stall_hmaster_data", Hmaster_data, 2'd1);
    Hreadyout = 1'b1;
    tick(5);
    check("resume_grant_hold", Hgrant, 3'b010);
    tick(1);
    check("resume_handover", Hgrant, 3'b100);

    // M2 drops; M1 is sole requester for 20 beats, passing the beat limit twice.
    Hbusreq = 3'b010;
    tick(1);
    check("sole_grant_m1", Hgrant, 3'b010);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check($sformatf("sole_hold_%0d", k), Hgrant, 3'b010);
    end
    Hbusreq = 3'b000;
    tick(1);
    check("sole_drop_grant", Hgrant, 3'b001);
    tick(1);
    check("sole_drop_hmaster", Hmaster, 2'd0);

    // IDLE from the owner hands over at once; BUSY neither hands over nor counts.
    Hbusreq = 3'b010;
    tick(1);
    check("idle_setup_grant", Hgrant, 3'b010);
    Hbusreq = 3'b110;
    Htrans  = 2'b00;
    tick(1);
    check("idle_handover", Hgrant, 3'b100);
    Htrans = 2'b01;
    tick(12);
    check("busy_hold", Hgrant, 3'b100);
    Htrans = 2'b10;
    tick(8);
    check("busy_nocount_hold", Hgrant, 3'b100);
    tick(1);
    check("busy_nocount_handover", Hgrant, 3'b010);

    // Asynchronous reset mid-burst of M1; outputs must clear before any edge.
    tick(3);
    check("pre_reset_hmaster", Hmaster, 2'd1);
    Hresetn = 1'b0;
    #2;
    check("async_rst_grant", Hgrant, 3'b001);
    check("async_rst_hmaster", Hmaster, 2'd0);
    check("async_rst_hmaster_data", Hmaster_data, 2'd0);
    check("async_rst_mastlock", Hmastlock, 1'b0);
    Hbusreq = 3'b000;
    tick(2);
    Hresetn = 1'b1;
    tick(1);
    check("post_rst_park", Hgrant, 3'b001);
    // Pointer restarts at the default master, so M1 precedes M2.
    Hbusreq = 3'b110;
    tick(1);
    check("post_rst_rr_ptr", Hgrant, 3'b010);

`ifdef BRIDGE_ARB_LOCK_EN
    Hbusreq = 3'b000;
    tick(1);
    check("lock_setup_park", Hgrant, 3'b001);
    Hbusreq = 3'b100;
    Hlock   = 3'b100;
    tick(1);
    check("lock_grant_m2", Hgrant, 3'b100);
    check("lock_first_mastlock", Hmastlock, 1'b0);
    Hbusreq = 3'b111;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      check($sformatf("lock_hold_grant_%0d", k), Hgrant, 3'b100);
      check($sformatf("lock_hold_mastlock_%0d", k), Hmastlock, 1'b1);
    end
    Hlock = 3'b000;
    tick(1);
    check("lock_exit_grant_m0", Hgrant, 3'b001);
    check("lock_exit_mastlock", Hmastlock, 1'b1);
    tick(1);
    check("lock_after_mastlock", Hmastlock, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
